// File: rtl/exec_sequencer.sv
// Micro-step sequencer: plays up to three (reg_load, select) steps of a decoded
// instruction, handshakes stack-memory steps, then advances EIP and requests the next fetch.
module exec_sequencer #(
  parameter int MAX_WAIT = 8,
  parameter int CODE_W   = 4,
  parameter int LEN_W    = 4
) (
  input  logic              clk2,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [2:0]        dec_step_en,
  input  logic [CODE_W-1:0] dec_load1,
  input  logic [CODE_W-1:0] dec_sel1,
  input  logic [CODE_W-1:0] dec_load2,
  input  logic [CODE_W-1:0] dec_sel2,
  input  logic [CODE_W-1:0] dec_load3,
  input  logic [CODE_W-1:0] dec_sel3,
  input  logic [LEN_W-1:0]  dec_len,
  output logic [CODE_W-1:0] alu_sel,
  output logic [CODE_W-1:0] reg_load,
  output logic              reg_we,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              eip_adv,
  output logic [LEN_W-1:0]  eip_inc,
  output logic              fetch_req,
  output logic              busy,
  output logic              fault
);

  // state   | meaning
  // IDLE    | waiting for a decoded instruction, dec_ready=1
  // STEP    | drive current step codes; reg_we, or mem_req for stack steps
  // MEMWAIT | hold mem_req until mem_ack or timeout
  // COMMIT  | commit a completed memory step
  // ADV     | EIP += length unless a step loaded EIP
  // FETCH   | one-cycle next-fetch request
  // FAULT   | sticky error, left only by reset
  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_MEMWAIT, S_COMMIT, S_ADV, S_FETCH, S_FAULT
  } state_t;

  localparam logic [CODE_W-1:0] LD_EIP   = CODE_W'(4);
  localparam logic [CODE_W-1:0] LD_STACK = CODE_W'(5);
  localparam logic [CODE_W-1:0] LD_STKWR = CODE_W'(8);

  state_t                   state, state_nx;
  logic [1:0]               idx, idx_nx;
  logic [2:0]               en_q, en_nx;
  logic [2:0][CODE_W-1:0]   load_q, load_nx, sel_q, sel_nx;
  logic [LEN_W-1:0]         len_q, len_nx;
  logic                     eipw_q, eipw_nx;
  logic [7:0]               wait_q, wait_nx;

  logic                     dec_ready_nx, reg_we_nx, mem_req_nx, eip_adv_nx;
  logic                     fetch_req_nx, busy_nx, fault_nx;
  logic [CODE_W-1:0]        alu_sel_nx, reg_load_nx;
  logic [LEN_W-1:0]         eip_inc_nx;

  logic [2:0]               first_step, next_step;
  logic [CODE_W-1:0]        cur_load, nx_load;

  // Returns {found, index} of the lowest set bit in mask.
  function automatic logic [2:0] pick(input logic [2:0] mask);
    if (mask[0])      return 3'b100;
    else if (mask[1]) return 3'b101;
    else if (mask[2]) return 3'b110;
    else              return 3'b000;
  endfunction

  function automatic logic [2:0] later_steps(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b110;
      2'd1:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_mem(input logic [CODE_W-1:0] code);
    return (code == LD_STACK) || (code == LD_STKWR);
  endfunction

  assign first_step = pick(dec_step_en);
  assign next_step  = pick(en_q & later_steps(idx));
  assign cur_load   = load_q[idx];
  assign nx_load    = load_nx[idx_nx];

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    en_nx    = en_q;
    load_nx  = load_q;
    sel_nx   = sel_q;
    len_nx   = len_q;
    eipw_nx  = eipw_q;
    wait_nx  = wait_q;
    case (state)
      S_IDLE: begin
        if (dec_valid) begin
          en_nx   = dec_step_en;
          load_nx = {dec_load3, dec_load2, dec_load1};
          sel_nx  = {dec_sel3, dec_sel2, dec_sel1};
          len_nx  = dec_len;
          eipw_nx = 1'b0;
          wait_nx = 8'd0;
          if (dec_len == '0 || dec_step_en == 3'b000) begin
            state_nx = S_FAULT;
          end else begin
            state_nx = S_STEP;
            idx_nx   = first_step[1:0];
          end
        end
      end
      S_STEP: begin
        if (is_mem(cur_load)) begin
          state_nx = S_MEMWAIT;
          wait_nx  = 8'(MAX_WAIT);
        end else begin
          if (cur_load == LD_EIP) eipw_nx = 1'b1;
          if (next_step[2]) begin
            state_nx = S_STEP;
            idx_nx   = next_step[1:0];
          end else begin
            state_nx = S_ADV;
          end
        end
      end
      S_MEMWAIT: begin
        // an ack in the final allowed cycle still completes the step
        if (mem_ack) begin
          state_nx = S_COMMIT;
          wait_nx  = 8'd0;
        end else if (wait_q <= 8'd1) begin
          state_nx = S_FAULT;
          wait_nx  = 8'd0;
        end else begin
          wait_nx = wait_q - 8'd1;
        end
      end
      S_COMMIT: begin
        if (next_step[2]) begin
          state_nx = S_STEP;
          idx_nx   = next_step[1:0];
        end else begin
          state_nx = S_ADV;
        end
      end
      S_ADV:   state_nx = S_FETCH;
      S_FETCH: state_nx = S_IDLE;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops in the state's own cycle.
  always_comb begin
    dec_ready_nx = 1'b0;
    alu_sel_nx   = '0;
    reg_load_nx  = '0;
    reg_we_nx    = 1'b0;
    mem_req_nx   = 1'b0;
    eip_adv_nx   = 1'b0;
    eip_inc_nx   = '0;
    fetch_req_nx = 1'b0;
    fault_nx     = 1'b0;
    busy_nx      = (state_nx != S_IDLE);
    case (state_nx)
      S_IDLE: dec_ready_nx = 1'b1;
      S_STEP: begin
        alu_sel_nx  = sel_nx[idx_nx];
        reg_load_nx = nx_load;
        if (is_mem(nx_load)) mem_req_nx = 1'b1;
        else                 reg_we_nx  = 1'b1;
      end
      S_MEMWAIT: begin
        alu_sel_nx  = sel_nx[idx_nx];
        reg_load_nx = nx_load;
        mem_req_nx  = 1'b1;
      end
      S_COMMIT: begin
        alu_sel_nx  = sel_nx[idx_nx];
        reg_load_nx = nx_load;
        reg_we_nx   = 1'b1;
      end
      S_ADV: begin
        eip_adv_nx = ~eipw_nx;
        eip_inc_nx = eipw_nx ? '0 : len_nx;
      end
      S_FETCH: fetch_req_nx = 1'b1;
      S_FAULT: fault_nx     = 1'b1;
      default: dec_ready_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      en_q      <= 3'b000;
      load_q    <= '0;
      sel_q     <= '0;
      len_q     <= '0;
      eipw_q    <= 1'b0;
      wait_q    <= 8'd0;
      dec_ready <= 1'b1;
      alu_sel   <= '0;
      reg_load  <= '0;
      reg_we    <= 1'b0;
      mem_req   <= 1'b0;
      eip_adv   <= 1'b0;
      eip_inc   <= '0;
      fetch_req <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      en_q      <= en_nx;
      load_q    <= load_nx;
      sel_q     <= sel_nx;
      len_q     <= len_nx;
      eipw_q    <= eipw_nx;
      wait_q    <= wait_nx;
      dec_ready <= dec_ready_nx;
      alu_sel   <= alu_sel_nx;
      reg_load  <= reg_load_nx;
      reg_we    <= reg_we_nx;
      mem_req   <= mem_req_nx;
      eip_adv   <= eip_adv_nx;
      eip_inc   <= eip_inc_nx;
      fetch_req <= fetch_req_nx;
      busy      <= busy_nx;
      fault     <= fault_nx;
    end
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Micro-step controller between the opcode decoder and the register file/ALU datapath.
- Accepts one decoded instruction per handshake: up to three (reg_load, select) step pairs, a step-enable mask and the instruction length.
- Drives the ALU input select and register load code one step per cycle, with a memory handshake on stack-access steps.
- Then advances EIP by the instruction length (unless a step wrote EIP) and requests the next fetch.

Parameters:
- MAX_WAIT, 8, clk2 cycles a memory step may wait for mem_ack before fault; range 1..255.
- CODE_W, 4, width of reg_load / select codes.
- LEN_W, 4, width of instruction length / EIP increment.

Ports:
- clk2  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- dec_valid  in  1  decoded instruction available.
- dec_ready  out  1  sequencer can accept an instruction.
- dec_step_en  in  3  bit i set = step i+1 present.
- dec_load1, dec_sel1, dec_load2, dec_sel2, dec_load3, dec_sel3  in  CODE_W each  per-step destination / ALU source codes.
- dec_len  in  LEN_W  instruction length in bytes.
- alu_sel  out  CODE_W  ALU input select for current step.
- reg_load  out  CODE_W  destination code for current step.
- reg_we  out  1  commit strobe for reg_load.
- mem_req  out  1  stack memory access request.
- mem_ack  in  1  stack memory access complete.
- eip_adv  out  1  one-cycle EIP += eip_inc strobe.
- eip_inc  out  LEN_W  increment value, valid with eip_adv.
- fetch_req  out  1  one-cycle next-fetch request.
- busy  out  1  state != IDLE.
- fault  out  1  sticky error flag.

Behaviour:
- All outputs registered (Moore). Reset (async, any state, mid-instruction included):
  - state=IDLE; dec_ready=1.
  - alu_sel=0, reg_load=0; reg_we, mem_req, eip_adv, fetch_req, busy, fault=0; eip_inc=0.
  - Latched instruction and wait counter cleared.
- States: IDLE, STEP, MEMWAIT, COMMIT, ADV, FETCH, FAULT.
- IDLE:
  - Accept on a clk2 edge with dec_valid & dec_ready.
  - Latch all dec_* fields; clear the eip_written flag.
  - If dec_len==0 or dec_step_en==0, go to FAULT.
  - Otherwise go to STEP at the lowest enabled step.
- Step order is 1, 2, 3; disabled steps are skipped with zero cycles.
- A step is a memory step when its load code is 4'h5 (stack access) or 4'h8 (stack write).
- STEP, non-memory step:
  - One cycle: alu_sel/reg_load = step codes, reg_we=1.
  - If the load code is 4'h4 (EIP), set eip_written.
  - Next: the next enabled step, else ADV.
- STEP, memory step:
  - Same codes driven, reg_we=0, mem_req=1; go to MEMWAIT.
- MEMWAIT:
  - Hold mem_req=1 and the step codes.
  - wait_cnt increments each cycle mem_ack is low.
  - mem_ack sampled high: go to COMMIT.
  - wait_cnt reaches MAX_WAIT with no ack: go to FAULT.
- COMMIT: one cycle, mem_req=0, reg_we=1, same codes; then the next enabled step, else ADV.
- ADV:
  - eip_written=0: eip_adv=1, eip_inc = latched dec_len.
  - eip_written=1: eip_adv=0, eip_inc=0 (jump/call/ret already loaded EIP).
- FETCH: fetch_req=1 for one cycle; then IDLE with dec_ready=1.
- dec_ready=1 only in IDLE. dec_valid while busy is ignored and the held fields are not sampled.
- Latency, no memory steps: dec_ready returns (n+2) cycles after the accept edge, where n = enabled steps.
- Latency, memory steps: add one COMMIT cycle per memory step plus its ack wait cycles.
- FAULT: fault=1, busy=1, dec_ready=0, all strobes 0. Held until reset.
- mem_ack asserted outside MEMWAIT is ignored.
- In MEMWAIT, mem_ack and the timeout in the same cycle: ack wins.
- reg_we, eip_adv, fetch_req never assert together. mem_req and reg_we never assert together.

Test Plan:
- push ebp:
  - Stimulus: en=3'b011, load1=1/sel1=2, load2=1/sel2=1, len=1.
  - Response: reg_we cycles 1,2 with codes (1,2),(1,1); eip_adv cycle 3 with inc=1; fetch_req cycle 4; dec_ready cycle 5.
- mov [ebp+d],eax:
  - Stimulus: en=3'b011, load1=5/sel1=5, load2=8/sel2=8, len=3; mem_ack high 2 cycles after each mem_req.
  - Response: two MEMWAIT+COMMIT pairs; reg_we only in COMMIT cycles; eip_inc=3.
- call:
  - Stimulus: en=3'b111, load3=4/sel3=2, len=5.
  - Response: three reg_we cycles; third has reg_load=4; ADV has eip_adv=0; fetch_req still pulses.
- Timeout:
  - Stimulus: memory step with mem_ack held low, MAX_WAIT=8.
  - Response: fault=1 after 8 MEMWAIT cycles; dec_ready stays 0; reset clears fault and returns dec_ready=1.
- Reset mid-instruction: reset asserted in MEMWAIT -> mem_req drops asynchronously, all outputs reach reset values, next instruction accepted normally.
- Sparse mask / illegal:
  - en=3'b100 -> only step 3 is executed, directly after accept.
  - len=0 -> FAULT with no reg_we.
